// File: rtl/uno_deck.sv
// uno_deck: builds the 108-card UNO deck, shuffles it with an LFSR-driven
// Fisher-Yates pass, then deals one card per granted draw request.
//
// Output handshake: o_drawn is a one-cycle valid pulse with no ready/back-
// pressure. While o_drawn = 1, o_card holds the dealt card and o_dest holds the
// one-hot player lane that owns it. The consumer must take it in that cycle.
module uno_deck #(
   parameter int          NUM_PLAYERS  = 4,
   parameter bit          SHUFFLE_EN   = 1'b1,
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [15:0]            i_seed,
   input  logic [NUM_PLAYERS-1:0] i_draw,
   output logic [5:0]             o_card,
   output logic                   o_drawn,
   output logic [NUM_PLAYERS-1:0] o_dest,
   output logic                   o_idle,
   output logic                   o_ready,
   output logic [6:0]             o_remain,
   output logic [2:0]             o_dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_PICK  = 3'd2;
   localparam logic [2:0] S_SWAP  = 3'd3;
   localparam logic [2:0] S_READY = 3'd4;
   localparam logic [2:0] S_DEAL  = 3'd5;

   localparam int         GW        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam logic [6:0] DECK_SIZE = 7'd108;
   localparam logic [6:0] LAST_IDX  = 7'd107;

   logic [2:0]             r_state;
   logic [5:0]             r_deck [0:107];
   logic [15:0]            r_lfsr;
   logic [6:0]             r_idx;    // fill write index
   logic [1:0]             r_fcol;   // fill color
   logic [4:0]             r_frem;   // position inside the 25-card color block
   logic [6:0]             r_i;      // shuffle upper index
   logic [6:0]             r_j;      // shuffle picked index
   logic [6:0]             r_ptr;    // next card to deal
   logic [NUM_PLAYERS-1:0] r_pend;
   logic [GW-1:0]          r_gnt;

   logic [15:0]            w_lfsr_next;
   logic [15:0]            w_seed;
   logic [3:0]             w_val;
   logic [5:0]             w_fill_card;
   logic [7:0]             w_i1;
   logic [6:0]             w_j;
   logic [GW-1:0]          w_gnt;
   logic [NUM_PLAYERS-1:0] w_gnt_onehot;
   logic [NUM_PLAYERS-1:0] w_clr_mask;

   // Galois LFSR step (x^16+x^14+x^13+x^11+1), seed selection, and the
   // scaled pick j = floor(lfsr[7:0] * (i+1) / 256), which always lands in 0..i.
   always_comb begin
      w_lfsr_next = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};
      w_seed      = (i_seed == 16'd0) ? SEED_DEFAULT : i_seed;
      w_i1        = {1'b0, r_i} + 8'd1;
      w_j         = 7'(({7'd0, r_lfsr[7:0]} * {7'd0, w_i1}) >> 8);
   end

   // Canonical card for the current fill slot: value 0 once, then 1..12 twice
   // (slot rem maps to value rem[4:1] + rem[0]); slots 100..107 are the wilds.
   always_comb begin
      w_val = r_frem[4:1] + {3'b000, r_frem[0]};
      if (r_idx >= 7'd104)      w_fill_card = 6'b011110;
      else if (r_idx >= 7'd100) w_fill_card = 6'b001101;
      else                      w_fill_card = {r_fcol, w_val};
   end

   // Fixed-priority arbiter: lowest pending lane wins.
   always_comb begin
      w_gnt = '0;
      for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
         if (r_pend[k]) w_gnt = GW'(k);
      end
      w_gnt_onehot = NUM_PLAYERS'(1) << r_gnt;
      w_clr_mask   = (r_state == S_DEAL) ? w_gnt_onehot : '0;
   end

   // Main FSM with fill counters, shuffle indices, LFSR and deal pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_lfsr  <= SEED_DEFAULT;
         r_idx   <= '0;
         r_fcol  <= '0;
         r_frem  <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
      end else if (i_start) begin
         r_state <= S_FILL;
         r_lfsr  <= w_seed;
         r_idx   <= '0;
         r_fcol  <= '0;
         r_frem  <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_FILL: begin
               if (r_idx == LAST_IDX) begin
                  r_i     <= LAST_IDX;
                  r_ptr   <= '0;
                  r_state <= SHUFFLE_EN ? S_PICK : S_READY;
               end else begin
                  r_idx <= r_idx + 7'd1;
                  if (r_frem == 5'd24) begin
                     r_frem <= '0;
                     r_fcol <= r_fcol + 2'd1;
                  end else begin
                     r_frem <= r_frem + 5'd1;
                  end
               end
            end
            S_PICK: begin
               r_j     <= w_j;
               r_lfsr  <= w_lfsr_next;
               r_state <= S_SWAP;
            end
            S_SWAP: begin
               if (r_i == 7'd1) begin
                  r_ptr   <= '0;
                  r_state <= S_READY;
               end else begin
                  r_i     <= r_i - 7'd1;
                  r_state <= S_PICK;
               end
            end
            S_READY: begin
               // An exhausted deck rebuilds on its own; the LFSR keeps running
               // so the next shuffle differs, and pending requests survive.
               if (r_ptr == DECK_SIZE) begin
                  r_state <= S_FILL;
                  r_idx   <= '0;
                  r_fcol  <= '0;
                  r_frem  <= '0;
               end else if (|r_pend) begin
                  r_gnt   <= w_gnt;
                  r_state <= S_DEAL;
               end
            end
            S_DEAL: begin
               r_ptr   <= r_ptr + 7'd1;
               r_state <= S_READY;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Deck storage: written in order during fill, two entries exchanged per swap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int n = 0; n < 108; n++) r_deck[n] <= '0;
      end else if (!i_start) begin
         if (r_state == S_FILL) begin
            r_deck[r_idx] <= w_fill_card;
         end else if (r_state == S_SWAP) begin
            r_deck[r_i] <= r_deck[r_j];
            r_deck[r_j] <= r_deck[r_i];
         end
      end
   end

   // Pending requests: new pulses always set their bit, even in the cycle the
   // same bit is being retired by a deal; i_start drops everything older.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_pend <= '0;
      else if (i_start) r_pend <= i_draw;
      else              r_pend <= (r_pend & ~w_clr_mask) | i_draw;
   end

   // Output decode straight from state.
   always_comb begin
      o_drawn     = (r_state == S_DEAL);
      o_card      = o_drawn ? r_deck[r_ptr] : 6'd0;
      o_dest      = o_drawn ? w_gnt_onehot : '0;
      o_ready     = (r_state == S_READY) || (r_state == S_DEAL);
      o_idle      = (r_state == S_READY) && (r_pend == '0);
      o_remain    = o_ready ? (DECK_SIZE - r_ptr) : 7'd0;
      o_dbg_state = r_state;
   end

endmodule

// File: tb/tb_uno_deck.sv
// tb_uno_deck: randomized draw traffic against a deck model built from the
// card rules, with a queue scoreboard checked by an independent monitor.
module tb_uno_deck;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;

   // shuffled instance
   logic        start = 1'b0;
   logic [15:0] seed = 16'd0;
   logic [3:0]  draw = 4'd0;
   logic [5:0]  card;
   logic        drawn;
   logic [3:0]  dest;
   logic        idle;
   logic        ready;
   logic [6:0]  remain;
   logic [2:0]  dbg_state;

   // canonical-order instance
   logic        b_start = 1'b0;
   logic [15:0] b_seed = 16'd0;
   logic [3:0]  b_draw = 4'd0;
   logic [5:0]  b_card;
   logic        b_drawn;
   logic [3:0]  b_dest;
   logic        b_idle;
   logic        b_ready;
   logic [6:0]  b_remain;
   logic [2:0]  b_dbg_state;

   uno_deck #(.NUM_PLAYERS(4), .SHUFFLE_EN(1'b1), .SEED_DEFAULT(16'hACE1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_seed(seed), .i_draw(draw),
      .o_card(card), .o_drawn(drawn), .o_dest(dest), .o_idle(idle), .o_ready(ready),
      .o_remain(remain), .o_dbg_state(dbg_state)
   );

   uno_deck #(.NUM_PLAYERS(4), .SHUFFLE_EN(1'b0), .SEED_DEFAULT(16'hACE1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_seed(b_seed), .i_draw(b_draw),
      .o_card(b_card), .o_drawn(b_drawn), .o_dest(b_dest), .o_idle(b_idle), .o_ready(b_ready),
      .o_remain(b_remain), .o_dbg_state(b_dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [5:0]  canon_deck [108];
   logic [5:0]  m_deck [108];
   logic [15:0] m_lfsr;
   int          m_ptr;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic lsb;
      lsb = s[0];
      s = s >> 1;
      if (lsb) s = s ^ 16'hB400;
      return s;
   endfunction

   function automatic void canon_build();
      int k;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         logic [1:0] cc;
         cc = 2'(c);
         canon_deck[k] = {cc, 4'd0};
         k++;
         for (int v = 1; v <= 12; v++) begin
            for (int r = 0; r < 2; r++) begin
               canon_deck[k] = {cc, 4'(v)};
               k++;
            end
         end
      end
      for (int w = 0; w < 4; w++) begin canon_deck[k] = 6'b001101; k++; end
      for (int w = 0; w < 4; w++) begin canon_deck[k] = 6'b011110; k++; end
   endfunction

   // Fisher-Yates from the top: j = floor(lfsr[7:0] * (i+1) / 256), then step LFSR.
   function automatic void model_rebuild();
      int j;
      logic [5:0] t;
      for (int n = 0; n < 108; n++) m_deck[n] = canon_deck[n];
      for (int i = 107; i >= 1; i--) begin
         j = (int'(m_lfsr[7:0]) * (i + 1)) / 256;
         m_lfsr = lfsr_step(m_lfsr);
         t = m_deck[i];
         m_deck[i] = m_deck[j];
         m_deck[j] = t;
      end
      m_ptr = 0;
   endfunction

   // ---------------- scoreboard ----------------
   logic [5:0] exp_q[$];
   int         out_cnt [4];
   logic [5:0] got_card_q[$];
   logic [3:0] got_dest_q[$];
   int         got_cyc_q[$];
   logic [5:0] mon_e;
   int         mon_k;

   task automatic push_exp(input int k);
      if (m_ptr == 108) model_rebuild();
      exp_q.push_back(m_deck[m_ptr]);
      m_ptr++;
      out_cnt[k]++;
   endtask

   // Called at posedge+1; holds the mask for exactly one cycle.
   task automatic issue(input logic [3:0] mask);
      for (int k = 0; k < 4; k++) if (mask[k]) push_exp(k);
      draw = mask;
      @(posedge clk); #1;
      draw = 4'd0;
   endtask

   // monitor: pops and compares whenever a card is presented
   always @(negedge clk) begin
      if (rst_n) begin
         if (drawn) begin
            if (exp_q.size() == 0) begin
               check("unexpected_card", {26'd0, card}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("card", {26'd0, card}, {26'd0, mon_e});
            end
            check("dest_onehot", {31'd0, $onehot(dest)}, 32'd1);
            mon_k = -1;
            for (int k = 0; k < 4; k++) if (dest[k]) mon_k = k;
            if (mon_k >= 0) begin
               check("dest_requested", {31'd0, (out_cnt[mon_k] > 0)}, 32'd1);
               if (out_cnt[mon_k] > 0) out_cnt[mon_k]--;
            end
            got_card_q.push_back(card);
            got_dest_q.push_back(dest);
            got_cyc_q.push_back(cyc);
         end else begin
            check("dest_when_idle", {28'd0, dest}, 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [15:0] s);
      seed  = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_lfsr = (s == 16'd0) ? 16'hACE1 : s;
      model_rebuild();
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      while (!ready && n < limit) begin @(posedge clk); #1; n++; end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
      check("drain", exp_q.size(), 32'd0);
   endtask

   task automatic random_draws(input int total);
      int issued, iter, room;
      logic [3:0] mask;
      issued = 0;
      iter = 0;
      while (issued < total && iter < 5000) begin
         iter++;
         mask = 4'($urandom_range(0, 15));
         room = total - issued;
         for (int k = 0; k < 4; k++) begin
            if (out_cnt[k] != 0) mask[k] = 1'b0;
            if (mask[k]) begin
               if (room > 0) room--;
               else mask[k] = 1'b0;
            end
         end
         if (mask != 4'd0) begin
            issued += $countones(mask);
            issue(mask);
         end else begin
            @(posedge clk); #1;
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      check("random_issue_count", issued, total);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, sz, base;
      int hist_g [64];
      int hist_e [64];

      for (int k = 0; k < 4; k++) out_cnt[k] = 0;
      canon_build();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_card", {26'd0, card}, 32'd0);
      check("rst_drawn", {31'd0, drawn}, 32'd0);
      check("rst_dest", {28'd0, dest}, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_remain", {25'd0, remain}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // start latency and fresh-deck outputs
      do_start(16'h1234);
      wait_ready(1000, n);
      check("start_to_ready", n, 32'd322);
      check("ready_remain", {25'd0, remain}, 32'd108);
      check("ready_idle", {31'd0, idle}, 32'd1);

      // simultaneous requests from players 0 and 2
      issue(4'b0101);
      wait_drain(50);
      sz = got_dest_q.size();
      if (sz >= 2) begin
         check("simul_first_dest", {28'd0, got_dest_q[sz-2]}, 32'd1);
         check("simul_second_dest", {28'd0, got_dest_q[sz-1]}, 32'd4);
         check("simul_spacing", got_cyc_q[sz-1] - got_cyc_q[sz-2], 32'd2);
      end else begin
         check("simul_card_count", sz, 32'd2);
      end
      check("simul_idle_after", {31'd0, idle}, 32'd1);
      check("simul_remain", {25'd0, remain}, 32'd106);

      // request re-asserted in the very cycle its bit is retired
      base = got_card_q.size();
      issue(4'b0001);
      n = 0;
      while (!drawn && n < 10) begin @(posedge clk); #1; n++; end
      check("reassert_first_seen", {31'd0, drawn}, 32'd1);
      push_exp(0);
      draw = 4'b0001;
      @(posedge clk); #1;
      draw = 4'd0;
      wait_drain(50);
      check("reassert_cards", got_card_q.size() - base, 32'd2);

      // full deck from seed 0x1234: exact order plus composition
      do_start(16'h1234);
      wait_ready(1000, n);
      base = got_card_q.size();
      random_draws(108);
      wait_drain(1000);
      check("full_deck_count", got_card_q.size() - base, 32'd108);
      for (int c = 0; c < 64; c++) begin hist_g[c] = 0; hist_e[c] = 0; end
      for (int c = 0; c < 108; c++) hist_e[canon_deck[c]]++;
      for (int c = base; c < got_card_q.size(); c++) hist_g[got_card_q[c]]++;
      for (int c = 0; c < 64; c++) begin
         if (hist_e[c] != 0 || hist_g[c] != 0) check("card_histogram", hist_g[c], hist_e[c]);
      end

      // exhaustion: automatic rebuild, then a pending request is served
      n = 0;
      while (ready && n < 20) begin @(posedge clk); #1; n++; end
      check("exhaust_ready_drops", {31'd0, ready}, 32'd0);
      issue(4'b0010);
      wait_ready(1000, n);
      check("rebuild_cycles", n + 1, 32'd322);
      wait_drain(50);
      check("rebuild_dest", {28'd0, got_dest_q[got_dest_q.size()-1]}, 32'd2);
      check("rebuild_remain", {25'd0, remain}, 32'd107);

      // zero seed falls back to the default seed
      do_start(16'd0);
      wait_ready(1000, n);
      random_draws(60);
      wait_drain(1000);
      check("seed0_remain", {25'd0, remain}, 32'd48);

      // i_start during shuffle drops a pending request
      do_start(16'h00FF);
      repeat (200) begin @(posedge clk); #1; end
      check("midshuffle_not_ready", {31'd0, ready}, 32'd0);
      draw = 4'b0010;
      @(posedge clk); #1;
      draw = 4'd0;
      repeat (5) begin @(posedge clk); #1; end
      base = got_card_q.size();
      do_start(16'h00FF);
      wait_ready(1000, n);
      check("restart_to_ready", n, 32'd322);
      repeat (20) begin @(posedge clk); #1; end
      check("restart_no_deal", got_card_q.size() - base, 32'd0);
      check("restart_idle", {31'd0, idle}, 32'd1);
      check("restart_remain", {25'd0, remain}, 32'd108);
      issue(4'b1000);
      wait_drain(50);
      check("restart_dest", {28'd0, got_dest_q[got_dest_q.size()-1]}, 32'd8);

      // canonical-order instance: first four cards to player 0
      b_seed  = 16'h5555;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      n = 0;
      while (!b_ready && n < 500) begin @(posedge clk); #1; n++; end
      check("b_start_to_ready", n, 32'd108);
      for (int t = 0; t < 4; t++) begin
         b_draw = 4'b0001;
         @(posedge clk); #1;
         b_draw = 4'd0;
         n = 0;
         while (!b_drawn && n < 10) begin @(posedge clk); #1; n++; end
         check("b_drawn_seen", {31'd0, b_drawn}, 32'd1);
         check("b_card", {26'd0, b_card}, {26'd0, canon_deck[t]});
         check("b_dest", {28'd0, b_dest}, 32'd1);
         @(posedge clk); #1;
      end
      check("b_remain", {25'd0, b_remain}, 32'd104);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #900000;
      n_fail++;
      $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
